updown_cmd_gen: RTL and testbench
=================================

Name: updown_cmd_gen

Overview:
- Upstream command stage for the 4-bit up/down T-flip-flop counter.
- Converts two raw, asynchronous, bouncy push-button inputs into clean, mutually exclusive, single-cycle up/down command pulses.
- Includes hold-to-auto-repeat.
- Outputs drive the counter's up and down inputs directly: up=1 counts up, down=1 counts down, both 0 holds.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a level change; legal range 1..255.
- REPEAT_DELAY, 16: cycles from the first pulse to the first auto-repeat pulse while held; 0 disables auto-repeat.
- REPEAT_RATE, 8: cycles between subsequent auto-repeat pulses; must be ≥1.
- CNT_W, 8: width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clock  input  1  system clock, rising edge.
- clear_b  input  1  synchronous, active-high reset.
- btn_up_raw  input  1  raw up button, asynchronous, may bounce.
- btn_down_raw  input  1  raw down button, asynchronous, may bounce.
- up  output  1  one-cycle count-up command to the counter.
- down  output  1  one-cycle count-down command to the counter.
- locked  output  1  high while both buttons are considered pressed (conflict lockout).

Behaviour:
- Reset: clear_b is sampled on the rising clock edge only.
  - During reset, all state clears: sync flops 0, filtered levels 0, counters 0, FSM in IDLE.
  - Outputs up=0, down=0, locked=0.
  - Reset asserted mid-hold or mid-debounce aborts the operation. No pulse is emitted in the cycle after reset deasserts.
- Synchronizer: 2-flop synchronizer per button.
- Debounce: each button has a filtered level `f` and a counter.
  - Counter increments while the synchronized value differs from `f`.
  - Counter clears when the two agree.
  - On reaching DEBOUNCE_CYCLES, `f` takes the synchronized value and the counter clears.
- Latency: edge 0 is the first edge that samples raw=1 (stable). `f` rises at edge DEBOUNCE_CYCLES+1. The first pulse is high for exactly the one cycle after edge DEBOUNCE_CYCLES+2.
- FSM states: IDLE, UP_HOLD, DN_HOLD, LOCK.
  - IDLE:
    - f_up & !f_dn: pulse up, load timer=REPEAT_DELAY, go to UP_HOLD.
    - f_dn & !f_up: pulse down, go to DN_HOLD (symmetric).
    - f_up & f_dn in the same cycle: no pulse, go to LOCK.
  - UP_HOLD:
    - f_up falls: go to IDLE, no pulse.
    - f_dn rises: go to LOCK, no pulse.
    - Otherwise, with REPEAT_DELAY≠0: decrement timer. When timer==1, pulse up next cycle and reload REPEAT_RATE.
  - DN_HOLD: symmetric to UP_HOLD.
  - LOCK: locked=1, no pulses. Return to IDLE only when f_up=0 and f_dn=0. Releasing one button does not resume the other.
- Invariants:
  - up & down is never 1 in the same cycle.
  - Each pulse is exactly 1 cycle wide.
  - up and down are registered outputs.
- Repeat timing: first repeat pulse is REPEAT_DELAY cycles after the initial pulse; subsequent repeat pulses are REPEAT_RATE cycles apart.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles never change `f` and produce no pulse.

Decomposition:
- Shared package updown_pkg:
  - FSM state enum (IDLE, UP_HOLD, DN_HOLD, LOCK, 2 bits).
  - Default constants for DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE.
  - CNT_W.
- Sub-module btn_debounce: 2-flop synchronizer plus debounce counter, output filtered level. Instantiated twice.
- Top module holds the FSM, the repeat timer and the output registers.

Test Plan (all with DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=8):
- Reset: assert clear_b for 2 cycles with both buttons high → up=0, down=0, locked=0 throughout reset and in the first cycle after it. Buttons are still high after release → FSM enters LOCK (locked=1 after debounce).
- Clean press: btn_up_raw 0→1 held 5 cycles, then released → exactly one up pulse, in the cycle after edge 6; down stays 0.
- Bounce: btn_up_raw toggles 1,0,1,0 every cycle, then holds 1 → no pulse during bouncing; one pulse 6 edges after the last 0→1 transition.
- Auto-repeat: btn_down_raw held 40 cycles after the first pulse → down pulses at offsets 0, 16, 24, 32, 40 relative to the first pulse; no up pulses.
- Conflict: hold up (pulse seen), then press down → no further pulses, locked=1. Release down only → still locked, no up pulses. Release both → locked=0 once debounced, FSM in IDLE.
- Integration: drive the counter from a clear (0000) with 3 up presses then 1 down press → counter reads 3, then 2; up and down are never simultaneously high.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared types and default constants for the up/down command generator.
package updown_pkg;

    // Default parameter values for the command stage
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int REPEAT_DELAY_DEF    = 16;
    localparam int REPEAT_RATE_DEF     = 8;
    localparam int CNT_W_DEF           = 8;

    // Hold/lockout controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UP_HOLD = 2'd1,
        DN_HOLD = 2'd2,
        LOCK    = 2'd3
    } hold_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debounce filter.
// The filtered level only follows the synchronized input after it has
// disagreed with it for DEBOUNCE_CYCLES samples in a row.
module btn_debounce
    import updown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic clear_b,
    input  logic raw_i,
    output logic level_o
);

    logic             sync1_q, sync2_q;
    logic             f_q, f_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; any agreement restarts the run
    always_comb begin
        f_d   = f_q;
        cnt_d = '0;
        if (sync2_q != f_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                f_d   = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, filtered level and run counter registers
    always_ff @(posedge clock) begin
        if (clear_b) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            f_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = f_q;

endmodule

// File: rtl/updown_cmd_gen.sv
// Up/down command generator: debounces two buttons and turns presses into
// mutually exclusive single-cycle up/down pulses with hold-to-repeat and a
// lockout while both buttons are held.
module updown_cmd_gen
    import updown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic clear_b,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic locked
);

    logic             f_up, f_dn;
    hold_state_e      state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             up_q, up_d;
    logic             dn_q, dn_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dbnc_up (
        .clock   (clock),
        .clear_b (clear_b),
        .raw_i   (btn_up_raw),
        .level_o (f_up)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dbnc_dn (
        .clock   (clock),
        .clear_b (clear_b),
        .raw_i   (btn_down_raw),
        .level_o (f_dn)
    );

    // Next-state, repeat timer and pulse decode for the hold controller
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (f_up && f_dn) begin
                    state_d = LOCK;
                end else if (f_up) begin
                    up_d    = 1'b1;
                    timer_d = CNT_W'(REPEAT_DELAY);
                    state_d = UP_HOLD;
                end else if (f_dn) begin
                    dn_d    = 1'b1;
                    timer_d = CNT_W'(REPEAT_DELAY);
                    state_d = DN_HOLD;
                end
            end
            UP_HOLD: begin
                if (!f_up) begin
                    state_d = IDLE;
                end else if (f_dn) begin
                    state_d = LOCK;
                end else if (REPEAT_DELAY != 0) begin
                    if (timer_q == CNT_W'(1)) begin
                        up_d    = 1'b1;
                        timer_d = CNT_W'(REPEAT_RATE);
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            DN_HOLD: begin
                if (!f_dn) begin
                    state_d = IDLE;
                end else if (f_up) begin
                    state_d = LOCK;
                end else if (REPEAT_DELAY != 0) begin
                    if (timer_q == CNT_W'(1)) begin
                        dn_d    = 1'b1;
                        timer_d = CNT_W'(REPEAT_RATE);
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            LOCK: begin
                // Only a full release leaves lockout; a single release never resumes the other button
                if (!f_up && !f_dn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer and registered command outputs
    always_ff @(posedge clock) begin
        if (clear_b) begin
            state_q <= IDLE;
            timer_q <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    assign up     = up_q;
    assign down   = dn_q;
    assign locked = (state_q == LOCK);

endmodule

// File: tb/tb_updown_cmd_gen.sv
// Self-checking bench for updown_cmd_gen: directed scenarios plus a
// randomized run against a behavioural press/hold model.
module tb_updown_cmd_gen;

    localparam int DB    = 4;
    localparam int DLY   = 16;
    localparam int RATE  = 8;
    localparam int NRAND = 1500;

    logic clock = 1'b0;
    logic clear_b = 1'b1;
    logic btn_up_raw = 1'b0;
    logic btn_down_raw = 1'b0;
    logic up, down, locked;

    int n_checks = 0;
    int n_fail = 0;
    int both_hi = 0;
    logic [3:0] cnt4 = 4'd0;

    bit su [0:2047];
    bit sd [0:2047];

    updown_cmd_gen #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_RATE     (RATE),
        .CNT_W           (8)
    ) dut (
        .clock        (clock),
        .clear_b      (clear_b),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .up           (up),
        .down         (down),
        .locked       (locked)
    );

    always #5 clock = ~clock;

    // Downstream 4-bit up/down counter driven by the command pulses
    always @(posedge clock) begin
        if (clear_b) cnt4 <= 4'd0;
        else if (up) cnt4 <= cnt4 + 4'd1;
        else if (down) cnt4 <= cnt4 - 4'd1;
    end

    always @(negedge clock) begin
        if (up === 1'b1 && down === 1'b1) both_hi++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset;
        clear_b = 1'b1;
        tick();
        tick();
        clear_b = 1'b0;
    endtask

    task automatic test_reset;
        btn_up_raw = 1'b1;
        btn_down_raw = 1'b1;
        clear_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({up, down, locked} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%b%b%b want=000", i, up, down, locked);
            end
        end
        clear_b = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            tick();
            n_checks++;
            if ({up, down} !== 2'b00 || locked !== (k >= 6)) begin
                n_fail++;
                $display("FAIL reset_lock k=%0d got up=%b dn=%b lk=%b want up=0 dn=0 lk=%b",
                         k, up, down, locked, (k >= 6));
            end
        end
        btn_up_raw = 1'b0;
        btn_down_raw = 1'b0;
    endtask

    task automatic test_clean_press;
        apply_reset();
        repeat (3) tick();
        btn_up_raw = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            tick();
            n_checks++;
            if (up !== (k == 6) || down !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_press k=%0d got up=%b dn=%b want up=%b dn=0", k, up, down, (k == 6));
            end
            if (k == 4) btn_up_raw = 1'b0;
        end
    endtask

    task automatic test_bounce;
        apply_reset();
        repeat (3) tick();
        btn_up_raw = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            tick();
            n_checks++;
            if (up !== (k == 10) || down !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce k=%0d got up=%b dn=%b want up=%b dn=0", k, up, down, (k == 10));
            end
            if (k == 0 || k == 2) btn_up_raw = 1'b0;
            if (k == 1 || k == 3) btn_up_raw = 1'b1;
            if (k == 15) btn_up_raw = 1'b0;
        end
    endtask

    task automatic test_auto_repeat;
        bit exp_dn;
        apply_reset();
        repeat (3) tick();
        btn_down_raw = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            tick();
            exp_dn = (k == 6) || (k == 22) || (k == 30) || (k == 38) || (k == 46);
            n_checks++;
            if (down !== exp_dn || up !== 1'b0 || locked !== 1'b0) begin
                n_fail++;
                $display("FAIL auto_repeat k=%0d got dn=%b up=%b lk=%b want dn=%b up=0 lk=0",
                         k, down, up, locked, exp_dn);
            end
            if (k == 47) btn_down_raw = 1'b0;
        end
    endtask

    task automatic test_conflict;
        bit exp_lk;
        apply_reset();
        repeat (3) tick();
        btn_up_raw = 1'b1;
        for (int k = 0; k <= 70; k++) begin
            tick();
            exp_lk = (k >= 17) && (k < 57);
            n_checks++;
            if (up !== (k == 6) || down !== 1'b0 || locked !== exp_lk) begin
                n_fail++;
                $display("FAIL conflict k=%0d got up=%b dn=%b lk=%b want up=%b dn=0 lk=%b",
                         k, up, down, locked, (k == 6), exp_lk);
            end
            if (k == 10) btn_down_raw = 1'b1;
            if (k == 30) btn_down_raw = 1'b0;
            if (k == 50) btn_up_raw = 1'b0;
        end
    endtask

    task automatic test_integration;
        apply_reset();
        repeat (3) tick();
        for (int p = 0; p < 4; p++) begin
            if (p < 3) btn_up_raw = 1'b1;
            else btn_down_raw = 1'b1;
            repeat (8) tick();
            btn_up_raw = 1'b0;
            btn_down_raw = 1'b0;
            repeat (12) tick();
            if (p == 2) begin
                n_checks++;
                if (cnt4 !== 4'd3) begin
                    n_fail++;
                    $display("FAIL integ_after_up got=%0d want=3", cnt4);
                end
            end
        end
        n_checks++;
        if (cnt4 !== 4'd2) begin
            n_fail++;
            $display("FAIL integ_after_down got=%0d want=2", cnt4);
        end
        n_checks++;
        if (both_hi !== 0) begin
            n_fail++;
            $display("FAIL up_down_overlap got=%0d cycles want=0", both_hi);
        end
    endtask

    // Model: a level is accepted once DB consecutive synchronized samples
    // disagree with it; a press pulses at once, then repeats at hold ages
    // DLY, DLY+RATE, ...; both held means lockout until both are released.
    task automatic test_random;
        int  ru, rd, age, mode;
        bit  mfu, mfd, eu, ed, allu, alld, vu, vd;
        apply_reset();
        ru = 0; rd = 0; age = 0; mode = 0;
        mfu = 1'b0; mfd = 1'b0;
        for (int e = 0; e < NRAND; e++) begin
            if (ru == 0) begin
                btn_up_raw = ~btn_up_raw;
                ru = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 50);
            end
            if (rd == 0) begin
                btn_down_raw = ~btn_down_raw;
                rd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 70);
            end
            ru--; rd--;
            su[e] = btn_up_raw;
            sd[e] = btn_down_raw;
            tick();
            eu = 1'b0; ed = 1'b0;
            case (mode)
                0: begin
                    if (mfu && mfd) mode = 3;
                    else if (mfu) begin mode = 1; age = 0; eu = 1'b1; end
                    else if (mfd) begin mode = 2; age = 0; ed = 1'b1; end
                end
                1: begin
                    if (!mfu) mode = 0;
                    else if (mfd) mode = 3;
                    else begin
                        age++;
                        eu = (age >= DLY) && ((age - DLY) % RATE == 0);
                    end
                end
                2: begin
                    if (!mfd) mode = 0;
                    else if (mfu) mode = 3;
                    else begin
                        age++;
                        ed = (age >= DLY) && ((age - DLY) % RATE == 0);
                    end
                end
                default: if (!mfu && !mfd) mode = 0;
            endcase
            allu = 1'b1; alld = 1'b1;
            for (int j = e - DB - 1; j <= e - 2; j++) begin
                vu = (j >= 0) ? su[j] : 1'b0;
                vd = (j >= 0) ? sd[j] : 1'b0;
                if (vu == mfu) allu = 1'b0;
                if (vd == mfd) alld = 1'b0;
            end
            if (allu) mfu = ~mfu;
            if (alld) mfd = ~mfd;
            n_checks++;
            if (up !== eu || down !== ed || locked !== (mode == 3)) begin
                n_fail++;
                $display("FAIL random e=%0d got up=%b dn=%b lk=%b want up=%b dn=%b lk=%b",
                         e, up, down, locked, eu, ed, (mode == 3));
            end
        end
        btn_up_raw = 1'b0;
        btn_down_raw = 1'b0;
        n_checks++;
        if (both_hi !== 0) begin
            n_fail++;
            $display("FAIL random_overlap got=%0d cycles want=0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_conflict();
        test_integration();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
